// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: shared segment encodings for the multiplexed 7-segment driver
package seg7_scan_driver_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam logic [0:15][6:0] HEX_SEG = {
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
endpackage

// File: rtl/seg7_scan_driver_hex7seg.sv
// hex7seg: hex nibble to active-low {a,b,c,d,e,f,g} segment pattern
module hex7seg
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] i_hex,
  output seg_t       o_seg
);
  assign o_seg = HEX_SEG[i_hex];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment scanner with double-buffered image load and blink
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NDIGITS   = 8,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [4*NDIGITS-1:0]   wr_data,
  input  logic [NDIGITS-1:0]     wr_blank,
  input  logic [NDIGITS-1:0]     wr_blink,
  output logic                   wr_ready,
  output logic [6:0]             seg_out,
  output logic [NDIGITS-1:0]     an_out,
  output logic                   frame_sync
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [SW-1:0]        r_slot;
  logic [DW-1:0]        r_digit;
  logic [FW-1:0]        r_frame;
  logic                 r_phase, r_pend;
  logic [4*NDIGITS-1:0] r_sh_data, r_d_data;
  logic [NDIGITS-1:0]   r_sh_blank, r_sh_blink, r_d_blank, r_d_blink;
  seg_t                 r_seg;
  logic [NDIGITS-1:0]   r_an;
  logic                 r_fs;
  logic                 w_slot_wrap, w_digit_wrap, w_bound, w_load, w_commit, w_off;
  logic [3:0]           w_nib;
  seg_t                 w_seg;
  logic [NDIGITS-1:0]   w_an;
  assign w_slot_wrap  = r_slot == SW'(SCAN_DIV - 1);
  assign w_digit_wrap = r_digit == DW'(NDIGITS - 1);
  assign w_bound      = w_slot_wrap && w_digit_wrap;
  assign w_load       = wr_en && !r_pend;
  // a load taken on the boundary cycle sees r_pend=0 here, so it waits a full frame
  assign w_commit     = w_bound && r_pend;
  assign w_nib        = r_d_data[{r_digit, 2'b00} +: 4];
  assign w_off        = r_d_blank[r_digit] || (r_d_blink[r_digit] && r_phase);
  assign w_an         = ~(NDIGITS'(1) << r_digit);
  assign wr_ready     = !r_pend;
  assign seg_out      = r_seg;
  assign an_out       = r_an;
  assign frame_sync   = r_fs;
  hex7seg u_dec (.i_hex(w_nib), .o_seg(w_seg));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot     <= '0;
      r_digit    <= '0;
      r_frame    <= '0;
      r_phase    <= 1'b0;
      r_pend     <= 1'b0;
      r_sh_data  <= '0;
      r_sh_blank <= '0;
      r_sh_blink <= '0;
      r_d_data   <= '0;
      r_d_blank  <= '1;
      r_d_blink  <= '0;
      r_seg      <= SEG_BLANK;
      r_an       <= '1;
      r_fs       <= 1'b0;
    end else begin
      r_slot <= w_slot_wrap ? '0 : r_slot + 1'b1;
      if (w_slot_wrap) r_digit <= w_digit_wrap ? '0 : r_digit + 1'b1;
      if (w_bound) begin
        r_frame <= (r_frame == FW'(BLINK_DIV - 1)) ? '0 : r_frame + 1'b1;
        if (r_frame == FW'(BLINK_DIV - 1)) r_phase <= ~r_phase;
      end
      if (w_load) begin
        r_sh_data  <= wr_data;
        r_sh_blank <= wr_blank;
        r_sh_blink <= wr_blink;
        r_pend     <= 1'b1;
      end else if (w_commit) begin
        r_d_data  <= r_sh_data;
        r_d_blank <= r_sh_blank;
        r_d_blink <= r_sh_blink;
        r_pend    <= 1'b0;
      end
      // slot 0 is dead time so the old and new anode never overlap
      r_seg <= w_off ? SEG_BLANK : w_seg;
      r_an  <= (r_slot == '0 || r_d_blank[r_digit]) ? '1 : w_an;
      r_fs  <= r_slot == '0 && r_digit == '0;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: position-based reference model checks of the scan driver every cycle
module tb_seg7_scan_driver;
  localparam int N = 4, S = 4, B = 2, FL = N * S;
  typedef struct {logic [3:0] nib; logic [6:0] seg;} dec_t;
  logic clk = 0, rst = 1, wr_en = 0;
  logic [15:0] wr_data = '0;
  logic [3:0] wr_blank = '0, wr_blink = '0;
  logic wr_ready, frame_sync;
  logic [6:0] seg_out;
  logic [3:0] an_out;
  dec_t tbl[16];
  int n_cmp = 0, n_bad = 0;
  int p = 0;
  bit m_pend = 0;
  logic [15:0] m_sd, m_dd;
  logic [3:0] m_sb, m_sk, m_db, m_dk;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic e_fs;
  always #5 clk = ~clk;
  seg7_scan_driver #(.NDIGITS(N), .SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_blank(wr_blank),
    .wr_blink(wr_blink), .wr_ready(wr_ready), .seg_out(seg_out), .an_out(an_out),
    .frame_sync(frame_sync));
  function automatic logic [6:0] dec(input logic [3:0] n);
    dec = 7'h7F;
    foreach (tbl[i]) if (tbl[i].nib == n) dec = tbl[i].seg;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t pos=%0d", name, act, exp, $time, p);
    end
  endtask
  task automatic step(input bit r, input bit e, input logic [15:0] d,
                      input logic [3:0] bl, input logic [3:0] bk);
    int slot, dig, ph;
    rst = r; wr_en = e; wr_data = d; wr_blank = bl; wr_blink = bk;
    #1;
    if (!r) check("wr_ready", wr_ready, !m_pend);
    @(posedge clk);
    if (r) begin
      e_seg = 7'h7F; e_an = 4'hF; e_fs = 0;
      p = 0; m_pend = 0; m_dd = '0; m_db = 4'hF; m_dk = '0;
    end else begin
      slot = p % S;
      dig = (p / S) % N;
      ph = ((p / FL) / B) % 2;
      e_seg = (m_db[dig] || (m_dk[dig] && ph == 1)) ? 7'h7F : dec(m_dd[4*dig +: 4]);
      e_an = (slot == 0 || m_db[dig]) ? 4'hF : ~(4'b0001 << dig);
      e_fs = (slot == 0 && dig == 0);
      if (e && !m_pend) begin
        m_sd = d; m_sb = bl; m_sk = bk; m_pend = 1;
      end else if (p % FL == FL - 1 && m_pend) begin
        m_dd = m_sd; m_db = m_sb; m_dk = m_sk; m_pend = 0;
      end
      p++;
    end
    #1;
    check("seg_out", seg_out, e_seg);
    check("an_out", an_out, e_an);
    check("frame_sync", frame_sync, e_fs);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0);
  endtask
  task automatic do_reset();
    step(1, 0, '0, '0, '0);
    step(1, 0, '0, '0, '0);
  endtask
  initial begin
    int fs_cnt;
    tbl = '{'{4'h0, 7'b0000001}, '{4'h1, 7'b1001111}, '{4'h2, 7'b0010010}, '{4'h3, 7'b0000110},
            '{4'h4, 7'b1001100}, '{4'h5, 7'b0100100}, '{4'h6, 7'b0100000}, '{4'h7, 7'b0001111},
            '{4'h8, 7'b0000000}, '{4'h9, 7'b0000100}, '{4'hA, 7'b0001000}, '{4'hB, 7'b1100000},
            '{4'hC, 7'b0110001}, '{4'hD, 7'b1000010}, '{4'hE, 7'b0110000}, '{4'hF, 7'b0111000}};
    // reset then idle: dark display, frame_sync every FL cycles
    do_reset();
    fs_cnt = 0;
    for (int i = 0; i < 3 * FL; i++) begin
      step(0, 0, '0, '0, '0);
      fs_cnt += frame_sync;
    end
    check("fs_count", fs_cnt, 3);
    // plain image
    step(0, 1, 16'h3210, 4'h0, 4'h0);
    idle(3 * FL);
    // second load while pending is ignored
    do_reset();
    step(0, 1, 16'h1234, 4'h0, 4'h0);
    step(0, 1, 16'h5678, 4'h2, 4'h0);
    idle(2 * FL);
    // load on the exact boundary cycle commits one frame later
    do_reset();
    idle(FL - 1);
    step(0, 1, 16'h9ABC, 4'h0, 4'h0);
    idle(3 * FL);
    // blinking digit 0
    do_reset();
    step(0, 1, 16'hFFFF, 4'h0, 4'h1);
    idle(6 * FL);
    // reset mid-frame with a load pending discards it
    idle(5);
    step(0, 1, 16'h4567, 4'h0, 4'h0);
    idle(3);
    step(1, 0, '0, '0, '0);
    idle(3 * FL);
    // decode table sweep, every digit showing the same nibble
    foreach (tbl[i]) begin
      step(0, 1, {4{tbl[i].nib}}, 4'h0, 4'h0);
      idle(2 * FL);
    end
    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, 16'($urandom),
           4'($urandom_range(0, 3) == 0 ? $urandom : 0), 4'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
